// File: rtl/mul_pkg.sv
// +--------------------------------------------------------------+
// | mul_pkg : shared width default and FSM state encoding         |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

package mul_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mul_pkg

`default_nettype wire

// File: rtl/mul_seq_if.sv
// +--------------------------------------------------------------+
// | mul_seq_if : request/result bundle of the sequential multiplier |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

interface mul_seq_if
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output start, A, B,
    input  busy, done, product_hi, product_lo
  );

  modport slave (
    input  start, A, B,
    output busy, done, product_hi, product_lo
  );

endinterface : mul_seq_if

`default_nettype wire

// File: rtl/mul_seq_adder.sv
// +--------------------------------------------------------------+
// | mul_seq_adder : unsigned WIDTH-bit adder with carry out       |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module mul_seq_adder
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b};

endmodule : mul_seq_adder

`default_nettype wire

// File: rtl/mul_seq.sv
// +--------------------------------------------------------------+
// | mul_seq : radix-2 shift-add unsigned multiplier, WIDTH steps  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_seq_if.slave bus
);

  localparam int                c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_carry;
  logic [WIDTH-1:0]   w_acc_sh;
  logic [WIDTH-1:0]   w_mq_sh;

  assign w_addend = mq_q[0] ? mcand_q : '0;

  mul_seq_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a         (acc_q),
    .b         (w_addend),
    .sum       (w_sum),
    .carry_out (w_carry)
  );

  // {carry, sum, mq} shifted right by one; the carry is consumed in the same step
  assign w_acc_sh = {w_carry, w_sum[WIDTH-1:1]};
  assign w_mq_sh  = {w_sum[0], mq_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.A;
          acc_d   = '0;
          mq_d    = bus.B;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = w_acc_sh;
        mq_d  = w_mq_sh;
        cnt_d = cnt_q + c_cnt_w'(1);
        if (cnt_q == c_last) begin
          hi_d    = w_acc_sh;
          lo_d    = w_mq_sh;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.product_hi = hi_q;
  assign bus.product_lo = lo_q;

endmodule : mul_seq

`default_nettype wire

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; product width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  multiplicand, unsigned; sampled only on the accepting edge.
REQ-006 SHALL have port B  input  WIDTH  multiplier, unsigned; sampled only on the accepting edge.
REQ-007 SHALL have port busy  output  1  high in LOAD-accepted CALC and DONE states.
REQ-008 SHALL have port done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have port product_hi  output  WIDTH  upper half of A*B.
REQ-010 SHALL have port product_lo  output  WIDTH  lower half of A*B.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC, DONE, registered outputs only.
REQ-012 In IDLE with start=1 at edge N, SHALL load multiplicand<=A, {carry,acc}<=0, mq<=B, iteration counter<=0, state<=CALC.
REQ-013 In CALC, each edge SHALL: if mq[0]=1 form {carry,acc}=acc+multiplicand (WIDTH+1 bits), else pass acc with carry=0; then shift {carry,acc,mq} right by one.
REQ-014 SHALL perform exactly WIDTH CALC iterations (edges N+1..N+WIDTH), no early termination; counter wraps never.
REQ-015 At edge N+WIDTH SHALL transition CALC->DONE and update product_hi<=acc, product_lo<=mq (final shifted values).
REQ-016 done SHALL be 1 only during DONE (cycle after edge N+WIDTH); edge N+WIDTH+1 SHALL return to IDLE, done<=0.
REQ-017 Total latency start-accept to done SHALL be WIDTH+1 edges (33 for WIDTH=32).
REQ-018 start while state != IDLE (CALC or DONE) SHALL be ignored; A/B changes during CALC SHALL not affect the result.
REQ-019 busy SHALL be 1 from edge N through end of DONE cycle, 0 in IDLE.
REQ-020 product_hi/product_lo SHALL hold the last result until the next DONE update; they SHALL not show intermediate values.
REQ-021 Result SHALL be exact unsigned 2*WIDTH-bit product; no overflow possible.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, busy=0, done=0, product_hi=0, product_lo=0, internal registers=0.
REQ-023 Reset asserted mid-CALC SHALL abort the operation; no done pulse after release; first start after release SHALL behave per REQ-012.
REQ-024 start sampled on the first edge after rst_n deasserts SHALL be accepted normally.

Structure
REQ-025 Shared package mul_pkg SHALL hold WIDTH default constant and state enumeration (IDLE, CALC, DONE).
REQ-026 SHALL instantiate one sub-module adder (inputs a, b WIDTH; outputs sum WIDTH, carry_out 1), companion to the team subtractor; FSM, counter and shift registers stay in mul_seq.

Verification
REQ-027 A=3, B=5, start 1 cycle -> done at edge 33 after accept, product_hi=0x00000000, product_lo=0x0000000F, busy low next cycle.
REQ-028 A=0xFFFFFFFF, B=0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001.
REQ-029 A=0x00010000, B=0x00010000 -> product_hi=0x00000001, product_lo=0x00000000; then A=0, B=0x12345678 -> both 0.
REQ-030 start=1 held continuously with A=7,B=6, A/B changed mid-CALC -> result 42, next accept only after return to IDLE (edge 34), done pulses exactly once per 34 cycles.
REQ-031 rst_n low at CALC iteration 10 -> outputs 0 immediately (asynchronously), no done; after release A=9,B=9 -> product_lo=0x51 at 33-cycle latency.
REQ-032 Randomized 1000 unsigned pairs vs reference model -> all products match, done width always 1 cycle.
